// File: rtl/fft_param_seq.sv
// Radix-2 FFT butterfly scheduler: validates the run parameters, then walks every stage/butterfly.
// Optional RUN-phase cycle budget is compiled in with FFT_SEQ_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | waiting for start; parameters latched on start
// CHECK   | latched parameters validated, counters cleared
// RUN     | issuing butterfly commands, advancing on bf_valid & bf_ready
// DONE    | one-cycle completion pulse
module fft_param_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  stage_number,
    input  logic [11:0] max_point_fft,
    input  logic [15:0] max_point_fft_core,
    output logic        bf_valid,
    input  logic        bf_ready,
    output logic [11:0] addr_a,
    output logic [11:0] addr_b,
    output logic [10:0] tw_idx,
    output logic [3:0]  stage_idx,
    output logic        busy,
    output logic        done,
    output logic        param_err,
    output logic        timeout
);

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_RUN, S_DONE} state_t;

    state_t      state;
    logic [3:0]  stg_n;
    logic [11:0] n_pts;
    logic        prm_ok;
    logic [3:0]  s_cnt;
    logic [10:0] b_cnt;

    logic        in_ok;
    logic        to_hit;
    logic        adv;
    logic        last_b;
    logic        last_s;
    logic [11:0] half_m1;
    logic [10:0] mask;
    logic [10:0] b_lo;
    logic [11:0] hi;
    logic [11:0] a_c;

`ifdef FFT_SEQ_TIMEOUT_EN
    logic [15:0] budget;
    logic [15:0] cyc_cnt;
    assign to_hit = (state == S_RUN) && (budget != 16'd0) && (cyc_cnt == budget);
`else
    // Without the timeout option the budget input has no effect.
    logic unused_core;
    assign unused_core = ^max_point_fft_core;
    assign to_hit      = 1'b0;
`endif

    assign in_ok   = (stage_number != 4'd0) && (stage_number <= 4'd11) &&
                     (max_point_fft == (12'd1 << stage_number));
    assign half_m1 = (n_pts >> 1) - 12'd1;
    assign last_b  = ({1'b0, b_cnt} == half_m1);
    assign last_s  = (s_cnt == stg_n - 4'd1);
    assign adv     = bf_valid && bf_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            stg_n  <= 4'd0;
            n_pts  <= 12'd0;
            prm_ok <= 1'b0;
            s_cnt  <= 4'd0;
            b_cnt  <= 11'd0;
`ifdef FFT_SEQ_TIMEOUT_EN
            budget  <= 16'd0;
            cyc_cnt <= 16'd0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        stg_n  <= stage_number;
                        n_pts  <= max_point_fft;
                        prm_ok <= in_ok;
`ifdef FFT_SEQ_TIMEOUT_EN
                        budget <= max_point_fft_core;
`endif
                        state  <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    s_cnt <= 4'd0;
                    b_cnt <= 11'd0;
`ifdef FFT_SEQ_TIMEOUT_EN
                    cyc_cnt <= 16'd0;
`endif
                    state <= prm_ok ? S_RUN : S_IDLE;
                end
                S_RUN: begin
`ifdef FFT_SEQ_TIMEOUT_EN
                    cyc_cnt <= cyc_cnt + 16'd1;
`endif
                    if (to_hit) begin
                        state <= S_IDLE;
                    end else if (adv) begin
                        if (last_b) begin
                            b_cnt <= 11'd0;
                            if (last_s) state <= S_DONE;
                            else        s_cnt <= s_cnt + 4'd1;
                        end else begin
                            b_cnt <= b_cnt + 11'd1;
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Butterfly b of stage s pairs the element at a_c with its partner 2^s above.
    assign mask = (11'd1 << s_cnt) - 11'd1;
    assign b_lo = b_cnt & mask;
    assign hi   = ({1'b0, b_cnt} >> s_cnt) << (s_cnt + 4'd1);
    assign a_c  = hi | {1'b0, b_lo};

    always_comb begin
        bf_valid  = 1'b0;
        addr_a    = 12'd0;
        addr_b    = 12'd0;
        tw_idx    = 11'd0;
        stage_idx = 4'd0;
        if (state == S_RUN) begin
            bf_valid  = !to_hit;
            addr_a    = a_c;
            addr_b    = a_c + (12'd1 << s_cnt);
            tw_idx    = b_lo << (stg_n - 4'd1 - s_cnt);
            stage_idx = s_cnt;
        end
    end

    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign param_err = (state == S_CHECK) && !prm_ok;
    assign timeout   = to_hit;

endmodule

// File: doc/fft_param_seq.md
FFT_PARAM_SEQ -- requirements
Module: fft_param_seq

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port start, input, 1 bit: request to run one FFT schedule.
REQ-004 SHALL have port stage_number, input, 4 bits: number of radix-2 stages.
REQ-005 SHALL have port max_point_fft, input, 12 bits: FFT length N.
REQ-006 SHALL have port max_point_fft_core, input, 16 bits: cycle budget for the RUN phase (0 = unlimited).
REQ-007 SHALL have port bf_valid, output, 1 bit: butterfly command valid.
REQ-008 SHALL have port bf_ready, input, 1 bit: butterfly core accepts the command.
REQ-009 SHALL have ports addr_a and addr_b, output, 12 bits each: operand addresses.
REQ-010 SHALL have port tw_idx, output, 11 bits: twiddle index.
REQ-011 SHALL have port stage_idx, output, 4 bits: current stage.
REQ-012 SHALL have ports busy, done, param_err and timeout, output, 1 bit each: status; done, param_err and timeout are single-cycle pulses.

Function
REQ-013 SHALL implement states IDLE, CHECK, RUN and DONE.
REQ-014 SHALL, in IDLE with start=1, latch stage_number, max_point_fft and max_point_fft_core, then go to CHECK on the next cycle.
REQ-015 SHALL ignore start in every state other than IDLE.
REQ-016 SHALL treat the parameters as valid only when 1 <= stage_number <= 11 and max_point_fft == 2^stage_number.
REQ-017 SHALL, in CHECK with invalid parameters, pulse param_err for one cycle and return to IDLE.
REQ-018 SHALL, in CHECK with valid parameters, clear the stage counter s, the butterfly counter b and the cycle counter, then enter RUN.
REQ-019 SHALL, in RUN, drive addr_a = ((b >> s) << (s+1)) | (b & (2^s - 1)), addr_b = addr_a + 2^s, tw_idx = (b & (2^s - 1)) << (stage_number-1-s) and stage_idx = s, with all values combinational from the registered counters.
REQ-020 SHALL drive bf_valid = 1 in RUN unless a timeout hit occurs in that cycle.
REQ-021 SHALL advance only when bf_valid and bf_ready are both 1.
  - On an advance: b increments.
  - When b = N/2-1: b wraps to 0 and s increments.
REQ-022 SHALL hold the outputs and all counters unchanged while bf_valid=1 and bf_ready=0.
REQ-023 SHALL, when the last butterfly (s = stage_number-1, b = N/2-1) is accepted, go to DONE; DONE pulses done for one cycle, then returns to IDLE.
REQ-024 SHALL drive busy = 1 in CHECK, RUN and DONE, and 0 in IDLE.
REQ-025 SHALL drive addr_a, addr_b, tw_idx and stage_idx to 0 outside RUN.
REQ-026 SHALL accept back-to-back runs: start in the cycle after DONE is accepted.

Reset
REQ-027 SHALL, when rst=1 at a clock edge (including mid-RUN), go to IDLE and clear all counters and latched parameters.
REQ-028 SHALL drive all outputs to 0 from the first cycle after reset.
REQ-029 SHALL NOT issue any pending done, param_err or timeout pulse after a reset.

Configuration
REQ-030 SHALL, when macro FFT_SEQ_TIMEOUT_EN is defined, include a 16-bit RUN cycle counter that increments on every RUN cycle regardless of bf_ready.
REQ-031 SHALL, with FFT_SEQ_TIMEOUT_EN defined, latched budget nonzero and counter == budget in RUN:
  - force bf_valid to 0;
  - pulse timeout for one cycle;
  - return to IDLE without pulsing done.
REQ-032 SHALL, with FFT_SEQ_TIMEOUT_EN undefined, contain no cycle counter, tie timeout to 0, and ignore max_point_fft_core.

Verification
REQ-033 SHALL cover: stage_number=3, N=8, core=110, bf_ready=1, start at cycle 0 -> CHECK at cycle 1, RUN at cycles 2-13, done at cycle 14, with this command sequence:
  - stage 0: pairs (0,1),(2,3),(4,5),(6,7), tw 0,0,0,0;
  - stage 1: pairs (0,2),(1,3),(4,6),(5,7), tw 0,2,0,2;
  - stage 2: pairs (0,4),(1,5),(2,6),(3,7), tw 0,1,2,3.
REQ-034 SHALL cover: the same run with bf_ready low every other cycle -> identical sequence with each command held while stalled, and done at cycle 26.
REQ-035 SHALL cover: stage_number=3 with N=16 -> param_err at cycle 1, bf_valid never asserted, and busy back to 0 at cycle 2.
REQ-036 SHALL cover: with FFT_SEQ_TIMEOUT_EN, N=8 and core=5 -> exactly 5 butterflies accepted, timeout pulse in the 6th RUN cycle, and no done.
REQ-037 SHALL cover: rst=1 during stage 1 -> all outputs 0 on the next cycle, and a subsequent start reruns from stage 0, b=0.
REQ-038 SHALL cover: start pulses while busy -> ignored, and the schedule is unchanged.
